// File: rtl/usb_debug_dma_if.sv
// USB debug DMA port bundle: transfer control, FIFO pop side and memory write side.
// The slave modport is the DMA engine; the master modport drives it.
interface usb_debug_dma_if;
    logic        i_start;
    logic        i_abort;
    logic [3:0]  i_bank;
    logic [23:0] i_address;
    logic [19:0] i_length;
    logic        o_busy;
    logic        i_fifo_empty;
    logic        o_fifo_read;
    logic [31:0] i_fifo_data;
    logic        o_mem_request;
    logic [3:0]  o_mem_bank;
    logic [23:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic        i_mem_ack;

    modport slave (
        input  i_start,
        input  i_abort,
        input  i_bank,
        input  i_address,
        input  i_length,
        output o_busy,
        input  i_fifo_empty,
        output o_fifo_read,
        input  i_fifo_data,
        output o_mem_request,
        output o_mem_bank,
        output o_mem_address,
        output o_mem_data,
        input  i_mem_ack
    );

    modport master (
        output i_start,
        output i_abort,
        output i_bank,
        output i_address,
        output i_length,
        input  o_busy,
        output i_fifo_empty,
        input  o_fifo_read,
        output i_fifo_data,
        input  o_mem_request,
        input  o_mem_bank,
        input  o_mem_address,
        input  o_mem_data,
        output i_mem_ack
    );
endinterface

// File: rtl/usb_debug_dma.sv
// Moves words from the USB receive FIFO into memory, one write per popped word.
// States: IDLE -> FETCH (pop) -> LATCH (data arrives) -> WRITE (wait for ack).
module usb_debug_dma (
    input logic           i_clk,
    input logic           i_reset_n,
    usb_debug_dma_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]  state;
    logic [18:0] count;
    logic [18:0] words;
    logic        busy;
    logic        fifo_read;
    logic        mem_request;
    logic [3:0]  mem_bank;
    logic [23:0] mem_address;
    logic [31:0] mem_data;

    // ceil(length/4); same result as (length+3)>>2 in 21 bits
    assign words = {1'b0, bus.i_length[19:2]}
                 + {18'd0, |bus.i_length[1:0]};

    // The pop strobe is registered, so it is raised on the edge that
    // enters or stays in FETCH and is visible during the FETCH cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            fifo_read   <= 1'b0;
            mem_request <= 1'b0;
            mem_bank    <= 4'd1;
            mem_address <= '0;
            mem_data    <= '0;
        end else if (bus.i_abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            fifo_read   <= 1'b0;
            mem_request <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    fifo_read <= 1'b0;
                    if (bus.i_start && (words != '0)) begin
                        mem_bank    <= bus.i_bank;
                        mem_address <= bus.i_address;
                        count       <= words;
                        busy        <= 1'b1;
                        fifo_read   <= !bus.i_fifo_empty;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_read) begin
                        fifo_read <= 1'b0;
                        state     <= LATCH;
                    end else begin
                        fifo_read <= !bus.i_fifo_empty;
                    end
                end
                LATCH: begin
                    mem_data    <= bus.i_fifo_data;
                    mem_request <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    if (bus.i_mem_ack) begin
                        mem_request <= 1'b0;
                        mem_address <= mem_address + 24'd1;
                        count       <= count - 19'd1;
                        if (count == 19'd1) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            fifo_read <= !bus.i_fifo_empty;
                            state     <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy        = busy;
    assign bus.o_fifo_read   = fifo_read;
    assign bus.o_mem_request = mem_request;
    assign bus.o_mem_bank    = mem_bank;
    assign bus.o_mem_address = mem_address;
    assign bus.o_mem_data    = mem_data;
endmodule

// File: tb/tb_usb_debug_dma.sv
// Bench for usb_debug_dma: FIFO and memory models with a write scoreboard.
// Expected writes are queued when a transfer is set up and checked on each ack.
module tb_usb_debug_dma;
    typedef struct packed {
        logic [3:0]  bank;
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    usb_debug_dma_if bus();

    usb_debug_dma dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fifo_mem [0:63];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic        stall = 1'b0;
    wr_t         exp_mem [0:63];
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          ack_delay = 0;

    assign bus.i_fifo_empty = (fifo_wr == fifo_rd) || stall;

    // FIFO model: word appears on i_fifo_data the cycle after the pop strobe
    initial begin : fifo_model
        logic        pend;
        logic [31:0] pw;
        pend = 1'b0;
        pw = '0;
        bus.i_fifo_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pend) begin
                bus.i_fifo_data = pw;
                pend = 1'b0;
            end
            if (bus.o_fifo_read === 1'b1) begin
                vectors++;
                if (bus.i_fifo_empty !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pop_while_empty: empty=%b required 0", bus.i_fifo_empty);
                end else begin
                    pw = fifo_mem[fifo_rd % 64];
                    fifo_rd++;
                    pend = 1'b1;
                end
            end
        end
    end

    // Memory model: acks after ack_delay cycles, checks hold-stability and order
    initial begin : mem_model
        int  wait_cnt;
        wr_t held;
        wr_t cur;
        wait_cnt = 0;
        held = '0;
        bus.i_mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            cur = {bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data};
            if (bus.o_mem_request === 1'b1) begin
                if (wait_cnt == 0) begin
                    held = cur;
                end else begin
                    vectors++;
                    if (cur !== held) begin
                        miscompares++;
                        $display("FAIL write_held: got %h required %h", cur, held);
                    end
                end
                if (wait_cnt >= ack_delay) begin
                    bus.i_mem_ack = 1'b1;
                    wait_cnt = 0;
                    vectors++;
                    if (exp_rd == exp_wr) begin
                        miscompares++;
                        $display("FAIL unexpected_write: got %h required none", cur);
                    end else begin
                        if (cur !== exp_mem[exp_rd % 64]) begin
                            miscompares++;
                            $display("FAIL write: got %h required %h",
                                     cur, exp_mem[exp_rd % 64]);
                        end
                        exp_rd++;
                    end
                end else begin
                    bus.i_mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.i_mem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fifo(input logic [31:0] d);
        fifo_mem[fifo_wr % 64] = d;
        fifo_wr++;
    endtask

    task automatic push_exp(input logic [3:0] b, input logic [23:0] a, input logic [31:0] d);
        exp_mem[exp_wr % 64] = {b, a, d};
        exp_wr++;
    endtask

    task automatic start_xfer(input logic [3:0] b, input logic [23:0] a, input logic [19:0] l);
        bus.i_bank = b;
        bus.i_address = a;
        bus.i_length = l;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int cyc);
        cyc = 0;
        while (bus.o_busy === 1'b1 && cyc < 5000) begin
            cyc++;
            tick();
        end
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", nm, bus.o_busy);
        end
    endtask

    task automatic wait_pops(input string nm, input int n);
        int c;
        int g;
        c = 0;
        g = 0;
        forever begin
            if (bus.o_fifo_read === 1'b1) c++;
            if (c >= n || g >= 40) break;
            tick();
            g++;
        end
        vectors++;
        if (c != n) begin
            miscompares++;
            $display("FAIL %s_pop_timeout: pops=%0d required %0d", nm, c, n);
        end
    endtask

    task automatic check_tail(input string nm, input int pops, input int need);
        vectors++;
        if (pops != need) begin
            miscompares++;
            $display("FAIL %s_pops: got %0d required %0d", nm, pops, need);
        end
        vectors++;
        if (exp_rd != exp_wr) begin
            miscompares++;
            $display("FAIL %s_writes: got %0d required %0d", nm, exp_rd, exp_wr);
        end
    endtask

    task automatic do_xfer(input string nm, input logic [3:0] b, input logic [23:0] a,
                           input logic [19:0] l, input int exp_cyc);
        int          n;
        int          p0;
        int          cyc;
        logic [31:0] d;
        n = (int'(l) + 3) / 4;
        p0 = fifo_rd;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            push_fifo(d);
            push_exp(b, a + 24'(i), d);
        end
        start_xfer(b, a, l);
        vectors++;
        if (bus.o_mem_bank !== b || bus.o_mem_address !== a) begin
            miscompares++;
            $display("FAIL %s_capture: got %h/%h required %h/%h",
                     nm, bus.o_mem_bank, bus.o_mem_address, b, a);
        end
        wait_idle(nm, cyc);
        if (exp_cyc > 0) begin
            vectors++;
            if (cyc != exp_cyc) begin
                miscompares++;
                $display("FAIL %s_busy_cycles: got %0d required %0d", nm, cyc, exp_cyc);
            end
        end
        check_tail(nm, fifo_rd - p0, n);
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        vectors += 6;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b required 0", bus.o_busy);
        end
        if (bus.o_fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fifo_read: got %b required 0", bus.o_fifo_read);
        end
        if (bus.o_mem_request !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_request: got %b required 0", bus.o_mem_request);
        end
        if (bus.o_mem_bank !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_bank: got %h required 1", bus.o_mem_bank);
        end
        if (bus.o_mem_address !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_address: got %h required 0", bus.o_mem_address);
        end
        if (bus.o_mem_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h required 0", bus.o_mem_data);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_xfer("basic", 4'd1, 24'h000100, 20'd8, 6);
        do_xfer("len5", 4'd3, 24'h001000, 20'd5, 6);
        do_xfer("wrap", 4'd7, 24'hFFFFFF, 20'd8, 6);
        do_xfer("long", 4'd15, 24'h00ABCD, 20'd30, 24);
    endtask

    task automatic test_len0();
        int p0;
        p0 = fifo_rd;
        push_fifo(32'hDEADBEEF);
        start_xfer(4'd3, 24'h000005, 20'd0);
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_busy: got %b required 0", bus.o_busy);
        end
        repeat (4) tick();
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_mem_request !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_idle: busy=%b req=%b required 0/0",
                     bus.o_busy, bus.o_mem_request);
        end
        vectors++;
        if (fifo_rd != p0) begin
            miscompares++;
            $display("FAIL len0_pops: got %0d required 0", fifo_rd - p0);
        end
        // the stray word is consumed by a normal 1-word transfer
        push_exp(4'd2, 24'h000010, 32'hDEADBEEF);
        start_xfer(4'd2, 24'h000010, 20'd4);
        begin
            int cyc;
            wait_idle("len0_drain", cyc);
        end
        check_tail("len0_drain", fifo_rd - p0, 1);
    endtask

    task automatic test_stall();
        int          p0;
        int          p1;
        int          g;
        int          cyc;
        logic [31:0] d;
        ack_delay = 3;
        p0 = fifo_rd;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            push_fifo(d);
            push_exp(4'd2, 24'h000040 + 24'(i), d);
        end
        start_xfer(4'd2, 24'h000040, 20'd12);
        g = 0;
        while (bus.o_mem_request !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        vectors++;
        if (bus.o_mem_request !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_request_timeout: req=%b required 1", bus.o_mem_request);
        end
        stall = 1'b1;
        p1 = fifo_rd;
        repeat (10) tick();
        vectors++;
        if (fifo_rd != p1) begin
            miscompares++;
            $display("FAIL stall_pops: got %0d required 0", fifo_rd - p1);
        end
        vectors++;
        if (bus.o_busy !== 1'b1 || bus.o_mem_request !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_wait: busy=%b req=%b required 1/0",
                     bus.o_busy, bus.o_mem_request);
        end
        stall = 1'b0;
        wait_idle("stall", cyc);
        check_tail("stall", fifo_rd - p0, 3);
        ack_delay = 0;
        tick();
    endtask

    task automatic test_abort();
        int          p0;
        int          cyc;
        logic [31:0] d [0:3];
        p0 = fifo_rd;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            push_fifo(d[i]);
        end
        push_exp(4'd4, 24'h000300, d[0]);
        start_xfer(4'd4, 24'h000300, 20'd16);
        wait_pops("abort", 2);
        tick();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_mem_request !== 1'b0 || bus.o_fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b req=%b rd=%b required 0/0/0",
                     bus.o_busy, bus.o_mem_request, bus.o_fifo_read);
        end
        repeat (3) tick();
        check_tail("abort", fifo_rd - p0, 2);
        // a new transfer picks up the remaining words normally
        push_exp(4'd5, 24'h000500, d[2]);
        push_exp(4'd5, 24'h000501, d[3]);
        start_xfer(4'd5, 24'h000500, 20'd8);
        wait_idle("abort_restart", cyc);
        vectors++;
        if (cyc != 6) begin
            miscompares++;
            $display("FAIL abort_restart_cycles: got %0d required 6", cyc);
        end
        check_tail("abort_restart", fifo_rd - p0, 4);
        tick();
    endtask

    task automatic test_back_to_back();
        int          p0;
        int          cyc;
        logic [31:0] d;
        p0 = fifo_rd;
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            push_fifo(d);
            push_exp(4'd2, 24'h000200 + 24'(i), d);
        end
        start_xfer(4'd2, 24'h000200, 20'd8);
        start_xfer(4'd9, 24'h000777, 20'd40);
        vectors++;
        if (bus.o_mem_bank !== 4'd2 || bus.o_mem_address !== 24'h000200) begin
            miscompares++;
            $display("FAIL busy_start_capture: got %h/%h required 2/000200",
                     bus.o_mem_bank, bus.o_mem_address);
        end
        wait_idle("busy_start", cyc);
        vectors++;
        if (cyc != 5) begin
            miscompares++;
            $display("FAIL busy_start_cycles: got %0d required 5", cyc);
        end
        check_tail("busy_start", fifo_rd - p0, 2);
        bus.i_abort = 1'b1;
        start_xfer(4'd8, 24'h000888, 20'd8);
        bus.i_abort = 1'b0;
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_mem_address !== 24'h000202) begin
            miscompares++;
            $display("FAIL start_abort: busy=%b addr=%h required 0/000202",
                     bus.o_busy, bus.o_mem_address);
        end
        repeat (3) tick();
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_late: busy=%b required 0", bus.o_busy);
        end
    endtask

    task automatic test_reset_mid();
        int          p0;
        logic [31:0] d [0:1];
        p0 = fifo_rd;
        d[0] = $urandom;
        d[1] = $urandom;
        push_fifo(d[0]);
        push_fifo(d[1]);
        push_exp(4'd6, 24'h000900, d[0]);
        start_xfer(4'd6, 24'h000900, 20'd8);
        wait_pops("reset_mid", 2);
        reset_n = 1'b0;
        tick();
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_mem_request !== 1'b0 || bus.o_fifo_read !== 1'b0
            || bus.o_mem_bank !== 4'd1 || bus.o_mem_address !== 24'h0
            || bus.o_mem_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b req=%b rd=%b bank=%h addr=%h data=%h required 0/0/0/1/0/0",
                     bus.o_busy, bus.o_mem_request, bus.o_fifo_read,
                     bus.o_mem_bank, bus.o_mem_address, bus.o_mem_data);
        end
        reset_n = 1'b1;
        repeat (4) tick();
        check_tail("reset_mid", fifo_rd - p0, 2);
    endtask

    initial begin : main
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_bank = '0;
        bus.i_address = '0;
        bus.i_length = '0;
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (fifo_rd != fifo_wr) begin
            miscompares++;
            $display("FAIL fifo_drained: got %0d required %0d", fifo_rd, fifo_wr);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/usb_debug_dma.md
USB_DEBUG_DMA -- requirements
Module: usb_debug_dma

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_reset_n  input  1  reset, synchronous, active-low.
REQ-004 i_start  input  1  one-cycle pulse that launches a transfer.
REQ-005 i_abort  input  1  level; cancels any transfer (driven on N64 reset/NMI).
REQ-006 i_bank  input  4  destination bank, sampled on accepted i_start.
REQ-007 i_address  input  24  destination word address, sampled on accepted i_start.
REQ-008 i_length  input  20  transfer length in bytes, sampled on accepted i_start.
REQ-009 o_busy  output  1  high while a transfer is in progress.
REQ-010 i_fifo_empty  input  1  USB receive FIFO has no word.
REQ-011 o_fifo_read  output  1  one-cycle pop strobe to the FIFO.
REQ-012 i_fifo_data  input  32  FIFO word, valid the cycle after o_fifo_read.
REQ-013 o_mem_request  output  1  memory write request, held until acknowledged.
REQ-014 o_mem_bank  output  4  bank of the current write.
REQ-015 o_mem_address  output  24  word address of the current write.
REQ-016 o_mem_data  output  32  data of the current write.
REQ-017 i_mem_ack  input  1  memory accepted the write in this cycle.

Function
REQ-018 All outputs SHALL be registered; the FSM SHALL have states IDLE, FETCH, LATCH and WRITE.
REQ-019 Word count SHALL be ceil(i_length/4), computed in 21-bit arithmetic as (i_length+3)>>2, range 0..262144.
REQ-020 IDLE: i_start with nonzero word count and i_abort low -> capture bank/address/count, go FETCH, o_busy=1 the next cycle.
REQ-021 i_start with word count 0 SHALL be ignored; the FSM stays in IDLE and o_busy stays 0.
REQ-022 i_start while o_busy=1 SHALL be ignored; captured bank/address/count SHALL stay unchanged.
REQ-023 FETCH: if i_fifo_empty=0, pulse o_fifo_read for exactly one cycle and go LATCH; otherwise hold in FETCH with no timeout.
REQ-024 LATCH: load i_fifo_data into o_mem_data, assert o_mem_request, go WRITE.
REQ-025 WRITE: hold o_mem_request, o_mem_bank, o_mem_address and o_mem_data stable until i_mem_ack=1.
REQ-026 On i_mem_ack in WRITE: drop o_mem_request next cycle, increment the address mod 2^24 (0xFFFFFF wraps to 0x000000, bank unchanged), and decrement the count.
REQ-027 After the ack, if the count was 1 the FSM SHALL go IDLE with o_busy=0 the next cycle; otherwise it SHALL go FETCH.
REQ-028 i_mem_ack outside WRITE SHALL be ignored.
REQ-029 o_fifo_read SHALL never assert while i_fifo_empty=1, nor outside FETCH.
REQ-030 Best case per word: FETCH, LATCH, WRITE (ack in first WRITE cycle) = 3 cycles; one pop per written word exactly.
REQ-031 i_abort=1 in any state SHALL force IDLE next cycle: o_mem_request=0, o_busy=0, o_fifo_read=0.
REQ-032 A word popped before the abort SHALL be discarded; a pending write SHALL be dropped.
REQ-033 i_abort and i_start in the same cycle: abort wins, no transfer starts.
REQ-034 o_mem_address/o_mem_bank SHALL reflect the captured values from the cycle after start.

Reset
REQ-035 i_reset_n=0 at a clock edge SHALL force IDLE, and takes priority over all other inputs.
REQ-036 Reset values: o_busy=0, o_fifo_read=0, o_mem_request=0, o_mem_bank=4'd1, o_mem_address=24'h000000, o_mem_data=32'h0, count=0.
REQ-037 Reset asserted mid-transfer SHALL abort as in REQ-031 with no further pops or writes.

Verification
REQ-038 Start bank=1, addr=0x000100, len=8, FIFO always ready, ack immediate: 2 pops, writes to 0x000100 and 0x000101 with FIFO data in order; o_busy high 6 cycles.
REQ-039 len=5 -> exactly 2 words written; len=0 -> no pop, no request, o_busy stays 0.
REQ-040 addr=0xFFFFFF, len=8: writes to 0xFFFFFF then 0x000000, bank unchanged.
REQ-041 FIFO empty for 10 cycles mid-transfer, ack delayed 3 cycles: no pop while empty, request and data held stable, word order preserved.
REQ-042 i_abort in LATCH of word 2 of 4: no write for word 2; IDLE and o_busy=0 the next cycle; a new start then runs normally.
REQ-043 i_start while busy, and start+abort in the same cycle: both ignored, captured values unchanged.
